counter_basic: RTL and testbench
================================

// Module: counter_basic
// PURPOSE
//   Free-running up-counter; advances one STEP per rising clk edge, wraps to zero past MAX_VALUE.
//   Leaf timing/sequence source for surrounding logic and bring-up demos; no enable or load input.
//   Output is fully registered, so it is glitch-free for downstream sampling.
// PARAMETERS
//   WIDTH      8                    count width in bits; legal range 2..32
//   STEP       1                    increment per clock; legal range 1..MAX_VALUE
//   MAX_VALUE  (1<<WIDTH)-1 (=255)  largest value count may hold before wrap
//   Illegal combinations -> elaboration-time $error, e.g. STEP=0 or MAX_VALUE > 2**WIDTH-1.
// PORTS
//   clk    in   1      sole clock; all state updates on posedge
//   rst    in   1      asynchronous, active-high reset
//   count  out  WIDTH  current counter value (registered)
//   wrap   out  1      only with COUNTER_BASIC_WRAP_PULSE_EN; registered one-cycle wrap pulse
// BEHAVIOUR
//   Reset: rst high forces count=0 (and wrap=0) immediately, with no clock needed.
//     While rst is high, count holds 0 across all edges.
//   Release: rst deasserts between edges; first posedge after deassertion gives count=STEP.
//     0 is held until that edge.
//   Count: each posedge, if (count + STEP) > MAX_VALUE then count<=0, else count<=count+STEP.
//     Comparison is done in WIDTH+1 bits, so no overflow aliasing occurs.
//   Defaults: 0,1,...,254,255,0,1,... giving period 256 cycles.
//   Non-divisor STEP: wrap lands on 0, not on the remainder (e.g. STEP=3, MAX=10: 9 -> 0).
//   Latency: count reflects an edge immediately after that edge; no combinational path input->count.
//   Reset mid-operation: async assert clears count on the same delta.
//     An edge coincident with assert is ignored; reset wins.
//   Before first reset assertion: count is X. Integration must pulse rst at power-up.
//   No state machine; the single state register is count.
// CONFIGURATION
//   Macro COUNTER_BASIC_WRAP_PULSE_EN.
//   Defined: adds port wrap, with behaviour as follows.
//     wrap<=1 on the edge where count loads 0 via the wrap rule, else wrap<=0.
//     So wrap=1 exactly in the cycle count shows the post-wrap 0.
//     wrap stays 0 for the 0 produced by reset. wrap resets to 0 asynchronously with rst.
//   Undefined: port wrap and its register do not exist; count behaviour is identical.
// STRUCTURE
//   Package counter_basic_pkg contains the following.
//     COUNTER_DEFAULT_WIDTH=8 and COUNTER_DEFAULT_STEP=1 defaults.
//     Function counter_max(width) returning (1<<width)-1.
//   Sub-module counter_basic_next: purely combinational next-state/wrap-detect.
//     Inputs: cur[WIDTH-1:0]. Outputs: nxt[WIDTH-1:0], wrapped.
//     Parameters WIDTH, STEP, MAX_VALUE.
//   Top holds parameter checks, async-reset count register, optional wrap register.
// TESTING  (clk period 10 ns)
//   1. Initial reset and release.
//      Stimulus: rst=1 at t=0, release at 12 ns.
//      Response: count=0 during reset; count=1,2,3... on successive edges; count=10 after 10 edges.
//   2. Async reset mid-count.
//      Stimulus: count=10; assert rst between edges for 10 ns.
//      Response: count=0 before the next edge; restarts 1,2,... after release.
//   3. Wrap.
//      Stimulus: run 256 edges from release.
//      Response: count 254 -> 255 -> 0 -> 1; no X, no hold at 255.
//   4. Parameterised wrap.
//      Stimulus: WIDTH=4, STEP=3, MAX_VALUE=10.
//      Response: sequence 0,3,6,9,0,3,...
//   5. Reset/edge collision.
//      Stimulus: assert rst on the same timestep as a posedge.
//      Response: count=0; no increment is visible.
//   6. Wrap pulse (macro defined).
//      Response: wrap=1 only in the cycle count=0 after 255.
//      Response: wrap=0 after reset and on all other cycles.

Source files
------------

// File: rtl/counter_basic_pkg.sv
// Shared defaults and helpers for the free-running counter_basic block.
package counter_basic_pkg;

  localparam int unsigned     COUNTER_DEFAULT_WIDTH = 8;
  localparam longint unsigned COUNTER_DEFAULT_STEP  = 1;

  // Largest value representable in `width` bits; 64-bit math keeps width=32 exact.
  function automatic longint unsigned counter_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/counter_basic_next.sv
// Combinational next-count and wrap detection for counter_basic.
module counter_basic_next
  import counter_basic_pkg::*;
#(
  parameter int unsigned     WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter longint unsigned STEP      = COUNTER_DEFAULT_STEP,
  parameter longint unsigned MAX_VALUE = counter_max(COUNTER_DEFAULT_WIDTH)
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             wrapped
);

  localparam logic [WIDTH:0] STEP_EXT = STEP[WIDTH:0];
  localparam logic [WIDTH:0] MAX_EXT  = MAX_VALUE[WIDTH:0];

  logic [WIDTH:0] sum;

  // The extra bit keeps cur+STEP from aliasing back below MAX_VALUE.
  always_comb begin
    sum     = {1'b0, cur} + STEP_EXT;
    wrapped = (sum > MAX_EXT);
    nxt     = wrapped ? '0 : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/counter_basic.sv
// Free-running up-counter with async reset; wraps to zero past MAX_VALUE.
// Define COUNTER_BASIC_WRAP_PULSE_EN to add a registered one-cycle wrap pulse output.
module counter_basic
  import counter_basic_pkg::*;
#(
  parameter int unsigned     WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter longint unsigned STEP      = COUNTER_DEFAULT_STEP,
  parameter longint unsigned MAX_VALUE = counter_max(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
  ,
  output logic             wrap
`endif
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_basic: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (MAX_VALUE > counter_max(WIDTH)) begin : g_bad_max
    $error("counter_basic: MAX_VALUE=%0d does not fit in WIDTH=%0d", MAX_VALUE, WIDTH);
  end
  if (STEP < 1 || STEP > MAX_VALUE) begin : g_bad_step
    $error("counter_basic: STEP=%0d outside 1..MAX_VALUE(%0d)", STEP, MAX_VALUE);
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] next_count;
  logic             next_wrapped;

  counter_basic_next #(
    .WIDTH     (WIDTH),
    .STEP      (STEP),
    .MAX_VALUE (MAX_VALUE)
  ) u_next (
    .cur     (count_q),
    .nxt     (next_count),
    .wrapped (next_wrapped)
  );

  always_comb begin
    count_d = next_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef COUNTER_BASIC_WRAP_PULSE_EN
  logic wrap_q, wrap_d;

  // High only for the 0 produced by wrapping, never for the 0 produced by reset.
  always_comb begin
    wrap_d = next_wrapped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  logic unused_next_wrapped;
  assign unused_next_wrapped = next_wrapped;
`endif

endmodule

// File: tb/tb_counter_basic.sv
// Directed self-checking bench for counter_basic (default and WIDTH=4/STEP=3/MAX=10 instances).
`timescale 1ns/1ps
module tb_counter_basic;

  logic       clk;
  logic       rst;
  logic [7:0] count;
  logic [3:0] count_p;
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
  logic       wrap;
  logic       wrap_p;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  counter_basic dut (
    .clk   (clk),
    .rst   (rst),
    .count (count)
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
    ,
    .wrap  (wrap)
`endif
  );

  counter_basic #(
    .WIDTH     (4),
    .STEP      (3),
    .MAX_VALUE (10)
  ) dut_p (
    .clk   (clk),
    .rst   (rst),
    .count (count_p)
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
    ,
    .wrap  (wrap_p)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp;
    int prev;
    int ptab[8];
    ptab = '{3, 6, 9, 0, 3, 6, 9, 0};

    // 1. Initial reset and release
    rst = 1'b1;
    #3;
    check("reset_async", 32'(count), 0);
    check("reset_async_p", 32'(count_p), 0);
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
    check("reset_wrap", 32'(wrap), 0);
`endif
    #4;  // t=7, after the edge at 5 with rst held
    check("reset_hold_edge", 32'(count), 0);
    #5;  // t=12
    rst = 1'b0;
    #1;
    check("release_hold", 32'(count), 0);
    for (int i = 1; i <= 10; i++) begin
      edge_sample();
      check($sformatf("count_up_%0d", i), 32'(count), 32'(i));
    end
    $display("[TB] initial reset/release: count=%0d after 10 edges", count);

    // 2. Async reset mid-count, asserted between edges for 10 ns
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_async", 32'(count), 0);
    edge_sample();
    check("mid_reset_hold", 32'(count), 0);
    #2;
    rst = 1'b0;
    $display("[TB] mid-count reset released");

    // 3/4. Long run through the 255->0 wrap, plus parameterised instance sequence
    exp = 0;
    for (int i = 0; i < 260; i++) begin
      edge_sample();
      prev = exp;
      exp  = (exp == 255) ? 0 : exp + 1;
      check($sformatf("run_%0d", i), 32'(count), 32'(exp));
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
      check($sformatf("wrap_%0d", i), 32'(wrap), (prev == 255) ? 1 : 0);
`endif
      if (i < 8) begin
        check($sformatf("param_seq_%0d", i), 32'(count_p), 32'(ptab[i]));
      end
      if (prev >= 254 || exp <= 1)
        $display("[TB] edge %0d: count=%0d", i, count);
    end

    // 5. Reset asserted in the same timestep as a posedge
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("collision_count", 32'(count), 0);
    check("collision_count_p", 32'(count_p), 0);
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
    check("collision_wrap", 32'(wrap), 0);
`endif
    #3;
    rst = 1'b0;
    edge_sample();
    check("post_collision_1", 32'(count), 1);
    check("post_collision_p", 32'(count_p), 3);
    edge_sample();
    check("post_collision_2", 32'(count), 2);
`ifdef COUNTER_BASIC_WRAP_PULSE_EN
    check("post_collision_wrap", 32'(wrap), 0);
`endif
    $display("[TB] reset/edge collision done: count=%0d", count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
